// File: rtl/inst_fetch.sv
// Instruction-fetch front end: drives the ROM address, buffers fetched words in a
// 2-entry prefetch FIFO and hands {pc, inst} pairs to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        ce_o,
  input  logic [31:0] inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [1:0]  buf_count_o
);

  typedef enum logic {S_BOOT, S_RUN} state_e;

  state_e      state_q;
  logic        ce_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_pc_d;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        rd_ptr_q;
  logic        rd_ptr_d;
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic [31:0] buf_pc_q   [2];
  logic [31:0] buf_inst_q [2];
  logic        push;
  logic        pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      ce_q    <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_RUN;
          ce_q    <= 1'b1;
        end
        S_RUN: begin
          state_q <= S_RUN;
          ce_q    <= 1'b1;
        end
        default: begin
          state_q <= S_BOOT;
          ce_q    <= 1'b0;
        end
      endcase
    end
  end

  // A redirect hides the head entry so decode can never consume a stale instruction.
  assign id_valid_o = (count_q != 2'd0) && !branch_flag_i;
  assign pop        = id_valid_o && id_ready_i;
  assign push       = ce_q && !branch_flag_i && ((count_q != 2'd2) || pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (branch_flag_i) begin
      fetch_pc_d = {branch_target_i[31:2], 2'b00};
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          buf_pc_q[gi]   <= 32'd0;
          buf_inst_q[gi] <= 32'd0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          buf_pc_q[gi]   <= fetch_pc_q;
          buf_inst_q[gi] <= inst_i;
        end
      end
    end
  endgenerate

  assign pc_o        = fetch_pc_q;
  assign ce_o        = ce_q;
  assign id_pc_o     = buf_pc_q[rd_ptr_q];
  assign id_inst_o   = buf_inst_q[rd_ptr_q];
  assign buf_count_o = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, streaming, backpressure, redirect, PC wrap
// and asynchronous reset, with a small combinational ROM model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [1:0]  buf_count_o;

  logic [31:0] pc_w;
  logic        ce_w;
  logic [31:0] inst_w;
  logic        br_w;
  logic [31:0] tgt_w;
  logic        rdy_w;
  logic        valid_w;
  logic [31:0] id_pc_w;
  logic [31:0] id_inst_w;
  logic [1:0]  count_w;

  int checks;
  int failures;

  // ROM word at byte address a is 0xA000_0000 + word index.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign inst_i = rom(pc_o);
  assign inst_w = rom(pc_w);

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc_o(pc_o), .ce_o(ce_o), .inst_i(inst_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .buf_count_o(buf_count_o)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_o(pc_w), .ce_o(ce_w), .inst_i(inst_w),
    .branch_flag_i(br_w), .branch_target_i(tgt_w),
    .id_ready_i(rdy_w), .id_valid_o(valid_w), .id_pc_o(id_pc_w),
    .id_inst_o(id_inst_w), .buf_count_o(count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] p,
                          input logic [31:0] i, input logic [1:0] c);
    chk({tag, "_valid"}, {31'd0, id_valid_o}, {31'd0, v});
    chk({tag, "_pc"}, id_pc_o, p);
    chk({tag, "_inst"}, id_inst_o, i);
    chk({tag, "_count"}, {30'd0, buf_count_o}, {30'd0, c});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc_o"}, pc_o, 32'd0);
    chk({tag, "_ce"}, {31'd0, ce_o}, 32'd0);
    chk_head(tag, 1'b0, 32'd0, 32'd0, 2'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_i = 32'd0;
    id_ready_i = 1'b1;
    br_w = 1'b0;
    tgt_w = 32'd0;
    rdy_w = 1'b1;

    // Reset state held across edges.
    tick();
    tick();
    chk_reset_state("rst");
    chk("wrap_rst_pc", pc_w, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b1;

    // Boot then stream with ready high.
    tick();
    chk("boot_ce", {31'd0, ce_o}, 32'd1);
    chk("boot_valid", {31'd0, id_valid_o}, 32'd0);
    chk("boot_pc", pc_o, 32'd0);
    tick();
    chk_head("s0", 1'b1, 32'h0, 32'hA000_0000, 2'd1);
    chk("wrap_first", id_pc_w, 32'hFFFF_FFFC);
    tick();
    chk_head("s1", 1'b1, 32'h4, 32'hA000_0001, 2'd1);
    chk("wrap_second", id_pc_w, 32'h0000_0000);
    chk("wrap_inst", id_inst_w, 32'hA000_0000);
    tick();
    chk_head("s2", 1'b1, 32'h8, 32'hA000_0002, 2'd1);
    tick();
    chk_head("s3", 1'b1, 32'hC, 32'hA000_0003, 2'd1);

    // Fresh boot for backpressure.
    rst = 1'b0;
    #1;
    chk_reset_state("rst2");
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    id_ready_i = 1'b0;
    #1;
    chk_head("bp0", 1'b1, 32'h0, 32'hA000_0000, 2'd1);
    tick();
    chk_head("bp1", 1'b1, 32'h0, 32'hA000_0000, 2'd2);
    chk("bp1_pc_o", pc_o, 32'h8);
    tick();
    tick();
    tick();
    tick();
    chk_head("bp5", 1'b1, 32'h0, 32'hA000_0000, 2'd2);
    chk("bp5_pc_o", pc_o, 32'h8);
    id_ready_i = 1'b1;
    #1;
    chk_head("rel0", 1'b1, 32'h0, 32'hA000_0000, 2'd2);
    tick();
    chk_head("rel1", 1'b1, 32'h4, 32'hA000_0001, 2'd2);
    chk("rel1_pc_o", pc_o, 32'hC);
    tick();
    chk_head("rel2", 1'b1, 32'h8, 32'hA000_0002, 2'd2);
    chk("rel2_pc_o", pc_o, 32'h10);

    // Single-cycle ready pulse at full occupancy.
    id_ready_i = 1'b0;
    tick();
    chk_head("hold", 1'b1, 32'h8, 32'hA000_0002, 2'd2);
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    #1;
    chk_head("pp", 1'b1, 32'hC, 32'hA000_0003, 2'd2);
    chk("pp_pc_o", pc_o, 32'h14);
    tick();
    chk("pp_hold_pc_o", pc_o, 32'h14);

    // Redirect while full, unaligned target.
    branch_flag_i = 1'b1;
    branch_target_i = 32'h0000_0006;
    #1;
    chk("br_valid", {31'd0, id_valid_o}, 32'd0);
    tick();
    branch_flag_i = 1'b0;
    #1;
    chk("br_count", {30'd0, buf_count_o}, 32'd0);
    chk("br_pc_o", pc_o, 32'h4);
    chk("br_valid_after", {31'd0, id_valid_o}, 32'd0);
    tick();
    chk_head("br_tgt", 1'b1, 32'h4, 32'hA000_0001, 2'd1);
    tick();
    chk("full_again", {30'd0, buf_count_o}, 32'd2);

    // Asynchronous reset at full occupancy, mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("arst");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("reboot_ce", {31'd0, ce_o}, 32'd1);
    chk("reboot_valid", {31'd0, id_valid_o}, 32'd0);
    tick();
    chk_head("reboot", 1'b1, 32'h0, 32'hA000_0000, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
